// File: rtl/idma_sync_256b_wdata_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : idma_sync_256b_wdata_fifo_if
// Brief    : Push/pop bundle between the iDMA data source, the write-data
//            FIFO and the 256-bit AXI write stage. IDMA_WDATA_FIFO_ERR_EN
//            adds the sticky error flags.
// Revision : 1.0
// ============================================================================
interface idma_sync_256b_wdata_fifo_if #(
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = AXI_DATA_WID / 8,
    parameter int DEPTH        = 16,
    parameter int AW           = $clog2(DEPTH)
);
    logic                    wr_cfg_init;
    logic                    wdata_push_valid;
    logic                    wdata_push_ready;
    logic [AXI_DATA_WID-1:0] wdata_push_data;
    logic [AXI_STRBW-1:0]    wdata_push_strb;
    logic                    wdata_fifo_pop;
    logic                    wdata_fifo_valid;
    logic [AXI_DATA_WID-1:0] wdata_fifo_data_d;
    logic [AXI_STRBW-1:0]    wdata_fifo_strb_d;
    logic                    wdata_fifo_empty_d;
    logic                    wdata_fifo_full;
    logic [AW:0]             wdata_fifo_cnt;
`ifdef IDMA_WDATA_FIFO_ERR_EN
    logic [1:0]              wdata_fifo_err;

    modport master (
        output wr_cfg_init, wdata_push_valid, wdata_push_data, wdata_push_strb, wdata_fifo_pop,
        input  wdata_push_ready, wdata_fifo_valid, wdata_fifo_data_d, wdata_fifo_strb_d,
        input  wdata_fifo_empty_d, wdata_fifo_full, wdata_fifo_cnt, wdata_fifo_err
    );
    modport slave (
        input  wr_cfg_init, wdata_push_valid, wdata_push_data, wdata_push_strb, wdata_fifo_pop,
        output wdata_push_ready, wdata_fifo_valid, wdata_fifo_data_d, wdata_fifo_strb_d,
        output wdata_fifo_empty_d, wdata_fifo_full, wdata_fifo_cnt, wdata_fifo_err
    );
`else
    modport master (
        output wr_cfg_init, wdata_push_valid, wdata_push_data, wdata_push_strb, wdata_fifo_pop,
        input  wdata_push_ready, wdata_fifo_valid, wdata_fifo_data_d, wdata_fifo_strb_d,
        input  wdata_fifo_empty_d, wdata_fifo_full, wdata_fifo_cnt
    );
    modport slave (
        input  wr_cfg_init, wdata_push_valid, wdata_push_data, wdata_push_strb, wdata_fifo_pop,
        output wdata_push_ready, wdata_fifo_valid, wdata_fifo_data_d, wdata_fifo_strb_d,
        output wdata_fifo_empty_d, wdata_fifo_full, wdata_fifo_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/idma_sync_256b_wdata_fifo.sv
`default_nettype none
// ============================================================================
// Module   : idma_sync_256b_wdata_fifo
// Brief    : Synchronous write-beat FIFO with registered pop output and
//            synchronous flush. IDMA_WDATA_FIFO_ERR_EN adds sticky error flags.
// Revision : 1.0
// ============================================================================
module idma_sync_256b_wdata_fifo #(
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = AXI_DATA_WID / 8,
    parameter int DEPTH        = 16,
    parameter int AW           = $clog2(DEPTH)
) (
    input  wire                            aclk,
    input  wire                            areset,
    idma_sync_256b_wdata_fifo_if.slave     bus
);
    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    logic [AXI_STRBW+AXI_DATA_WID-1:0] mem_q [DEPTH];

    logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    empty_q, empty_d, full_q, full_d, valid_q, valid_d;
    logic [AXI_DATA_WID-1:0] data_q, data_d;
    logic [AXI_STRBW-1:0]    strb_q, strb_d;
    logic                    w_push_acc, w_pop_acc;

    assign w_push_acc = bus.wdata_push_valid & ~full_q;
    assign w_pop_acc  = bus.wdata_fifo_pop & ~empty_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        strb_d  = strb_q;
        // Flush wins over any push/pop in the same cycle; output beat registers keep their value.
        if (bus.wr_cfg_init) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (w_push_acc) begin
                wp_d = wp_q + AW'(1);
            end
            if (w_pop_acc) begin
                rp_d    = rp_q + AW'(1);
                valid_d = 1'b1;
                data_d  = mem_q[rp_q][AXI_DATA_WID-1:0];
                strb_d  = mem_q[rp_q][AXI_STRBW+AXI_DATA_WID-1:AXI_DATA_WID];
            end
            cnt_d = cnt_q + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop_acc};
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == c_FULL_CNT);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    // Storage needs no reset: occupancy tracking alone decides which entries are live.
    always_ff @(posedge aclk) begin
        if (w_push_acc && !bus.wr_cfg_init) begin
            mem_q[wp_q] <= {bus.wdata_push_strb, bus.wdata_push_data};
        end
    end

    assign bus.wdata_push_ready   = ~full_q;
    assign bus.wdata_fifo_valid   = valid_q;
    assign bus.wdata_fifo_data_d  = data_q;
    assign bus.wdata_fifo_strb_d  = strb_q;
    assign bus.wdata_fifo_empty_d = empty_q;
    assign bus.wdata_fifo_full    = full_q;
    assign bus.wdata_fifo_cnt     = cnt_q;

`ifdef IDMA_WDATA_FIFO_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q | {bus.wdata_push_valid & full_q, bus.wdata_fifo_pop & empty_q};
        if (bus.wr_cfg_init) begin
            err_d = 2'b00;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.wdata_fifo_err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idma_sync_256b_wdata_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_idma_sync_256b_wdata_fifo
// Brief    : Directed bench for the write-data FIFO (default parameters).
// Revision : 1.0
// ============================================================================
module tb_idma_sync_256b_wdata_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errs    = 0;
    logic [255:0] exp_q[$];
    logic [255:0] e;

    always #5 clk = ~clk;

    idma_sync_256b_wdata_fifo_if #(.AXI_DATA_WID(256), .DEPTH(16)) bus ();

    idma_sync_256b_wdata_fifo #(.AXI_DATA_WID(256), .DEPTH(16)) dut (
        .aclk   (clk),
        .areset (rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [255:0] d);
        bus.wdata_push_valid = 1'b1;
        bus.wdata_push_data  = d;
        tick();
        bus.wdata_push_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.wr_cfg_init      = 1'b0;
        bus.wdata_push_valid = 1'b0;
        bus.wdata_push_data  = '0;
        bus.wdata_push_strb  = '1;
        bus.wdata_fifo_pop   = 1'b0;
        #12;
        check("rst_cnt",   bus.wdata_fifo_cnt, 0);
        check("rst_empty", bus.wdata_fifo_empty_d, 1);
        check("rst_full",  bus.wdata_fifo_full, 0);
        check("rst_ready", bus.wdata_push_ready, 1);
        check("rst_valid", bus.wdata_fifo_valid, 0);
        check("rst_data",  bus.wdata_fifo_data_d, 0);
        check("rst_strb",  bus.wdata_fifo_strb_d, 0);
        rst = 1'b0;
        tick();

        // basic push then pop
        push_beat(256'hA1);
        check("b_empty_fall", bus.wdata_fifo_empty_d, 0);
        push_beat(256'hA2);
        push_beat(256'hA3);
        check("b_cnt3", bus.wdata_fifo_cnt, 3);
        bus.wdata_fifo_pop = 1'b1;
        tick();
        check("b_v1", bus.wdata_fifo_valid, 1);
        check("b_d1", bus.wdata_fifo_data_d, 256'hA1);
        check("b_s1", bus.wdata_fifo_strb_d, 256'hFFFF_FFFF);
        tick();
        check("b_d2", bus.wdata_fifo_data_d, 256'hA2);
        tick();
        check("b_d3", bus.wdata_fifo_data_d, 256'hA3);
        check("b_cnt0", bus.wdata_fifo_cnt, 0);
        check("b_empty", bus.wdata_fifo_empty_d, 1);
        bus.wdata_fifo_pop = 1'b0;
        tick();
        check("b_vlow", bus.wdata_fifo_valid, 0);

        // fill to full, hold off beat 17, drain across wrap
        for (int i = 0; i < 16; i++) push_beat(256'(100 + i));
        check("f_full",  bus.wdata_fifo_full, 1);
        check("f_ready", bus.wdata_push_ready, 0);
        check("f_cnt",   bus.wdata_fifo_cnt, 16);
        bus.wdata_push_valid = 1'b1;
        bus.wdata_push_data  = 256'd200;
        tick();
        check("f_hold_cnt", bus.wdata_fifo_cnt, 16);
`ifdef IDMA_WDATA_FIFO_ERR_EN
        check("f_err1", bus.wdata_fifo_err, 2'b10);
`endif
        bus.wdata_fifo_pop = 1'b1;
        tick();
        check("f_pop_d", bus.wdata_fifo_data_d, 100);
        check("f_ready_back", bus.wdata_push_ready, 1);
        check("f_cnt15", bus.wdata_fifo_cnt, 15);
        bus.wdata_fifo_pop = 1'b0;
        tick();
        bus.wdata_push_valid = 1'b0;
        check("f_b17_cnt", bus.wdata_fifo_cnt, 16);
        bus.wdata_fifo_pop = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            e = (i == 16) ? 256'd200 : 256'(100 + i);
            check("f_drain", bus.wdata_fifo_data_d, e);
        end
        bus.wdata_fifo_pop = 1'b0;
        tick();
        check("f_empty", bus.wdata_fifo_empty_d, 1);

        // simultaneous push and pop at cnt=5
        for (int i = 0; i < 5; i++) begin
            push_beat(256'(300 + i));
            exp_q.push_back(256'(300 + i));
        end
        bus.wdata_push_valid = 1'b1;
        bus.wdata_fifo_pop   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wdata_push_data = 256'(400 + i);
            exp_q.push_back(256'(400 + i));
            tick();
            e = exp_q.pop_front();
            check("s_data", bus.wdata_fifo_data_d, e);
            check("s_cnt",  bus.wdata_fifo_cnt, 5);
        end
        bus.wdata_fifo_pop = 1'b0;
        bus.wdata_push_data = 256'd410;
        tick();
        bus.wdata_push_data = 256'd411;
        tick();
        check("s_cnt7", bus.wdata_fifo_cnt, 7);

        // flush with concurrent push and pop
        bus.wr_cfg_init      = 1'b1;
        bus.wdata_fifo_pop   = 1'b1;
        bus.wdata_push_data  = 256'd412;
        tick();
        bus.wr_cfg_init      = 1'b0;
        bus.wdata_push_valid = 1'b0;
        bus.wdata_fifo_pop   = 1'b0;
        check("fl_cnt",   bus.wdata_fifo_cnt, 0);
        check("fl_empty", bus.wdata_fifo_empty_d, 1);
        check("fl_full",  bus.wdata_fifo_full, 0);
        check("fl_valid", bus.wdata_fifo_valid, 0);
        check("fl_hold",  bus.wdata_fifo_data_d, 404);
`ifdef IDMA_WDATA_FIFO_ERR_EN
        check("fl_err", bus.wdata_fifo_err, 2'b00);
`endif
        push_beat(256'd500);
        bus.wdata_fifo_pop = 1'b1;
        tick();
        check("fl_new_v", bus.wdata_fifo_valid, 1);
        check("fl_new_d", bus.wdata_fifo_data_d, 500);

        // pop while empty is ignored
        tick();
        check("e_valid", bus.wdata_fifo_valid, 0);
        check("e_cnt",   bus.wdata_fifo_cnt, 0);
        check("e_hold",  bus.wdata_fifo_data_d, 500);
`ifdef IDMA_WDATA_FIFO_ERR_EN
        check("e_err0", bus.wdata_fifo_err, 2'b01);
`endif
        bus.wdata_fifo_pop = 1'b0;
        tick();
`ifdef IDMA_WDATA_FIFO_ERR_EN
        check("e_err_sticky", bus.wdata_fifo_err, 2'b01);
`endif
        push_beat(256'd600);
        bus.wdata_fifo_pop = 1'b1;
        tick();
        bus.wdata_fifo_pop = 1'b0;
        check("e_rp_ok", bus.wdata_fifo_data_d, 600);

        // asynchronous reset mid-stream at cnt=9
        for (int i = 0; i < 10; i++) push_beat(256'(700 + i));
        bus.wdata_fifo_pop = 1'b1;
        tick();
        bus.wdata_fifo_pop = 1'b0;
        check("r_cnt9", bus.wdata_fifo_cnt, 9);
        check("r_v",    bus.wdata_fifo_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_cnt",   bus.wdata_fifo_cnt, 0);
        check("ar_empty", bus.wdata_fifo_empty_d, 1);
        check("ar_ready", bus.wdata_push_ready, 1);
        check("ar_valid", bus.wdata_fifo_valid, 0);
        check("ar_data",  bus.wdata_fifo_data_d, 0);
        #1 rst = 1'b0;
        tick();
        push_beat(256'd800);
        bus.wdata_fifo_pop = 1'b1;
        tick();
        bus.wdata_fifo_pop = 1'b0;
        check("ar_new_d", bus.wdata_fifo_data_d, 800);
        tick();
        check("ar_empty2", bus.wdata_fifo_empty_d, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
`default_nettype wire
